reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/mips_pkg.sv | 25 ++
 rtl/reg_word.sv | 22 ++
 rtl/reg_file_mp.sv | 86 ++++++++
 tb/tb_reg_file_mp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants and the byte-lane merge used by both the
// storage words and the write-to-read forwarding path.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREG_MIPS  = 2 ** ADDR_W_DEF;

  // Widest word the merge helper supports; callers cast in and out.
  localparam int MERGE_W = 256;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_word,
    input logic [MERGE_W-1:0]   new_word,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MERGE_W / 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_word.sv
// One register-file word: per-byte write enable, synchronous active-high clear.
module reg_word
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   d,
  output logic [DATA_W-1:0]   q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (|be) begin
      q <= DATA_W'(byte_merge(MERGE_W'(q), MERGE_W'(d), (MERGE_W/8)'(be)));
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, two-read register file with byte enables, optional hardwired
// zero register and optional same-cycle write-to-read forwarding.
module reg_file_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [ADDR_W-1:0]   Ard1,
  input  logic [ADDR_W-1:0]   Ard2,
  output logic [DATA_W-1:0]   Dout1,
  output logic [DATA_W-1:0]   Dout2,
  input  logic [ADDR_W-1:0]   Awr0,
  input  logic [ADDR_W-1:0]   Awr1,
  input  logic [DATA_W-1:0]   Din0,
  input  logic [DATA_W-1:0]   Din1,
  input  logic                WrEn0,
  input  logic                WrEn1,
  input  logic [DATA_W/8-1:0] WrBe0,
  input  logic [DATA_W/8-1:0] WrBe1
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int BW   = DATA_W / 8;

  logic [NREG-1:0][DATA_W-1:0] q_all;

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BW-1:0]     be
  );
    return DATA_W'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_word), (MERGE_W/8)'(be)));
  endfunction

  // Port 1 is merged last so it wins any byte both ports enable.
  function automatic logic [DATA_W-1:0] read_word(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] w;
    w = stored;
    if (BYPASS != 0 && !Rst) begin
      if (WrEn0 && Awr0 == a) w = merge_w(w, Din0, WrBe0);
      if (WrEn1 && Awr1 == a) w = merge_w(w, Din1, WrBe1);
    end
    if (ZERO_REG != 0 && a == '0) w = '0;
    return w;
  endfunction

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign q_all[i] = '0;
    end else begin : g_word
      logic [BW-1:0]     be0;
      logic [BW-1:0]     be1;
      logic [BW-1:0]     be_all;
      logic [DATA_W-1:0] d_all;

      assign be0    = (WrEn0 && Awr0 == ADDR_W'(i)) ? WrBe0 : '0;
      assign be1    = (WrEn1 && Awr1 == ADDR_W'(i)) ? WrBe1 : '0;
      assign be_all = be0 | be1;
      assign d_all  = merge_w(merge_w('0, Din0, be0), Din1, be1);

      reg_word #(
        .DATA_W(DATA_W)
      ) u_word (
        .clk(Clk),
        .rst(Rst),
        .be (be_all),
        .d  (d_all),
        .q  (q_all[i])
      );
    end
  end

  always_comb begin
    Dout1 = read_word(Ard1, q_all[Ard1]);
    Dout2 = read_word(Ard2, q_all[Ard2]);
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against a word-array model.
module tb_reg_file_mp;

  logic        Clk;
  logic        Rst;
  logic [4:0]  Ard1, Ard2, Awr0, Awr1;
  logic [31:0] Dout1, Dout2, Din0, Din1;
  logic        WrEn0, WrEn1;
  logic [3:0]  WrBe0, WrBe1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  reg_file_mp #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Ard1 (Ard1),
    .Ard2 (Ard2),
    .Dout1(Dout1),
    .Dout2(Dout2),
    .Awr0 (Awr0),
    .Awr1 (Awr1),
    .Din0 (Din0),
    .Din1 (Din1),
    .WrEn0(WrEn0),
    .WrEn1(WrEn1),
    .WrBe0(WrBe0),
    .WrBe1(WrBe1)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Value a reader sees now: stored word, overlaid byte by byte with pending writes.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] w;
    if (a == 5'd0) return 32'd0;
    w = mem[a];
    if (!Rst) begin
      for (int b = 0; b < 4; b++) begin
        if (WrEn1 && Awr1 == a && WrBe1[b]) w[8*b +: 8] = Din1[8*b +: 8];
        else if (WrEn0 && Awr0 == a && WrBe0[b]) w[8*b +: 8] = Din0[8*b +: 8];
      end
    end
    return w;
  endfunction

  task automatic tick();
    logic [31:0] n0, n1;
    logic [4:0]  a0, a1;
    a0 = Awr0; a1 = Awr1;
    n0 = exp_read(a0);
    n1 = exp_read(a1);
    @(posedge Clk);
    if (Rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else begin
      if (a0 != 5'd0) mem[a0] = n0;
      if (a1 != 5'd0) mem[a1] = n1;
    end
    #1;
  endtask

  task automatic idle();
    Rst = 0; WrEn0 = 0; WrEn1 = 0; WrBe0 = 4'h0; WrBe1 = 4'h0;
    Din0 = 32'd0; Din1 = 32'd0; Awr0 = 5'd0; Awr1 = 5'd0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    WrEn0 = 1; Awr0 = a; Din0 = d; WrBe0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    WrEn1 = 1; Awr1 = a; Din1 = d; WrBe1 = be;
  endtask

  task automatic test_reset();
    idle(); Rst = 1; tick(); tick(); idle();
    for (int i = 0; i < 32; i += 5) begin
      Ard1 = 5'(i); Ard2 = 5'(31 - i); #1;
      checks++;
      if (Dout1 !== 32'd0 || Dout2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_clear addr=%0d got %h/%h want 0", i, Dout1, Dout2);
      end
    end
    wr0(5'd7, 32'hDEADBEEF, 4'hF); tick(); idle();
    Ard1 = 5'd7; #1;
    checks++;
    if (Dout1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL r7_write got %h want deadbeef", Dout1);
    end
    Rst = 1; tick(); Rst = 0; #1;
    checks++;
    if (Dout1 !== 32'd0) begin
      errors++; $display("FAIL r7_after_reset got %h want 0", Dout1);
    end
  endtask

  task automatic test_write_read();
    idle(); wr0(5'd3, 32'd32, 4'hF); Ard2 = 5'd3; #1;
    checks++;
    if (Dout2 !== 32'd32) begin
      errors++; $display("FAIL bypass_same_cycle got %h want 32", Dout2);
    end
    tick(); idle(); #1;
    checks++;
    if (Dout2 !== 32'd32) begin
      errors++; $display("FAIL read_next_cycle got %h want 32", Dout2);
    end
  endtask

  task automatic test_dual_conflict();
    idle(); wr0(5'd10, 32'd0, 4'hF); tick(); idle();
    wr0(5'd10, 32'h11111111, 4'hF); wr1(5'd10, 32'h22222222, 4'h3);
    Ard1 = 5'd10; #1;
    checks++;
    if (Dout1 !== 32'h11112222) begin
      errors++; $display("FAIL conflict_bypass got %h want 11112222", Dout1);
    end
    tick(); idle(); #1;
    checks++;
    if (Dout1 !== 32'h11112222) begin
      errors++; $display("FAIL conflict_stored got %h want 11112222", Dout1);
    end
  endtask

  task automatic test_byte_enable();
    idle(); wr1(5'd5, 32'hAABBCCDD, 4'hF); tick(); idle();
    wr0(5'd5, 32'h00000000, 4'h2); Ard1 = 5'd5; Ard2 = 5'd5; #1;
    checks++;
    if (Dout1 !== 32'hAABB00DD) begin
      errors++; $display("FAIL be_bypass got %h want aabb00dd", Dout1);
    end
    tick(); idle(); #1;
    checks++;
    if (Dout1 !== 32'hAABB00DD || Dout2 !== Dout1) begin
      errors++; $display("FAIL be_stored got %h/%h want aabb00dd", Dout1, Dout2);
    end
    // enabled write with no byte lanes must neither store nor forward
    wr0(5'd5, 32'h12345678, 4'h0); wr1(5'd5, 32'h9ABCDEF0, 4'h0); #1;
    checks++;
    if (Dout1 !== 32'hAABB00DD) begin
      errors++; $display("FAIL be_zero_fwd got %h want aabb00dd", Dout1);
    end
    tick(); idle(); #1;
    checks++;
    if (Dout1 !== 32'hAABB00DD) begin
      errors++; $display("FAIL be_zero_store got %h want aabb00dd", Dout1);
    end
  endtask

  task automatic test_zero_reg();
    idle(); wr0(5'd0, 32'hFFFFFFFF, 4'hF); wr1(5'd0, 32'hFFFFFFFF, 4'hF);
    Ard1 = 5'd0; Ard2 = 5'd0; #1;
    checks++;
    if (Dout1 !== 32'd0 || Dout2 !== 32'd0) begin
      errors++; $display("FAIL r0_same_cycle got %h/%h want 0", Dout1, Dout2);
    end
    tick(); idle(); #1;
    checks++;
    if (Dout1 !== 32'd0) begin
      errors++; $display("FAIL r0_next_cycle got %h want 0", Dout1);
    end
  endtask

  task automatic test_reset_vs_write();
    idle(); wr0(5'd2, 32'h00000077, 4'hF); tick(); idle();
    Rst = 1; wr0(5'd2, 32'd5, 4'hF); Ard1 = 5'd2; #1;
    checks++;
    if (Dout1 !== 32'h00000077) begin
      errors++; $display("FAIL rst_no_forward got %h want 00000077", Dout1);
    end
    tick(); idle(); #1;
    checks++;
    if (Dout1 !== 32'd0) begin
      errors++; $display("FAIL rst_beats_write got %h want 0", Dout1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Rst   = ($urandom_range(0, 39) == 0);
      WrEn0 = $urandom_range(0, 3) != 0;
      WrEn1 = $urandom_range(0, 3) != 0;
      Awr0  = 5'($urandom_range(0, 7));
      Awr1  = 5'($urandom_range(0, 7));
      Din0  = $urandom;
      Din1  = $urandom;
      WrBe0 = 4'($urandom);
      WrBe1 = 4'($urandom);
      Ard1  = ($urandom_range(0, 1) != 0) ? Awr0 : 5'($urandom_range(0, 9));
      Ard2  = ($urandom_range(0, 1) != 0) ? Awr1 : 5'($urandom);
      #1;
      checks++;
      if (Dout1 !== exp_read(Ard1) || Dout2 !== exp_read(Ard2)) begin
        errors++;
        $display("FAIL random n=%0d a1=%0d got %h want %h a2=%0d got %h want %h",
                 n, Ard1, Dout1, exp_read(Ard1), Ard2, Dout2, exp_read(Ard2));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); Ard1 = 5'd0; Ard2 = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 'x;
    test_reset();
    test_write_read();
    test_dual_conflict();
    test_byte_enable();
    test_zero_reg();
    test_reset_vs_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
